// File: rtl/reg_file_mp.sv
// Multi-read-port register file with one write port, optional zero register and a clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         wena_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
    output logic                         busy_o,
    output logic                         wr_drop_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic wr_accept;
    logic wr_store;
    logic clr_we;
    logic zero_waddr;

    assign zero_waddr = (ZERO_REG != 0) && (waddr_i == '0);
    assign busy_o     = (state_q == StClear);
    assign wr_drop_o  = wr_drop_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_we    = 1'b0;
        wr_accept = wena_i && (state_q == StIdle) && !clr_i && !rst;
        // Writes to a hard-wired zero entry are accepted but never stored.
        wr_store  = wr_accept && !zero_waddr;
        wr_drop_d = wena_i && !wr_accept;
        if (clr_i) begin
            state_d = StClear;
            cnt_d   = '0;
        end else if (state_q == StClear) begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LastIdx) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // The array itself is not reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_store) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  fwd_hit;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REG_FILE_MP_BYPASS_EN
        assign fwd_hit = wr_store && (ra == waddr_i);
`else
        assign fwd_hit = 1'b0;
`endif

        always_comb begin
            if (busy_o) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (fwd_hit) begin
                rd = wdata_i;
            end else begin
                rd = mem_q[ra];
            end
        end

        assign rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with three read ports; read expectations go through a queue.
module tb_reg_file_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 3;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             clr;
    logic             wena;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             busy;
    logic             wr_drop;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    logic [DW-1:0] exp_q [$];

    reg_file_mp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR),
        .ZERO_REG  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .wena_i   (wena),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .raddr_i  (raddr),
        .rdata_o  (rdata),
        .busy_o   (busy),
        .wr_drop_o(wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        raddr = {a2, a1, a0};
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    task automatic check_rd(input string tag);
        logic [DW-1:0] e;
        #1;
        for (int i = 0; i < NR; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), (NR*DW)'(rdata[i*DW +: DW]), (NR*DW)'(e));
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wena  = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wena  = 1'b0;
    endtask

    // Counts edges until busy drops, checking that reads stay zero throughout.
    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            check({tag, "_rd_zero"}, rdata, '0);
            tick();
            cycles++;
        end
        check({tag, "_busy_low"}, (NR*DW)'(busy), '0);
    endtask

    initial begin
        rst   = 1'b1;
        clr   = 1'b0;
        wena  = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = {5'd3, 5'd2, 5'd1};

        // Reset held for two edges, then the 32-entry sweep.
        tick();
        check("rst_busy", (NR*DW)'(busy), (NR*DW)'(1));
        check("rst_wr_drop", (NR*DW)'(wr_drop), '0);
        tick();
        rst = 1'b0;
        wait_idle("reset_sweep", n);
        check("reset_sweep_len", (NR*DW)'(n), (NR*DW)'(32));
        set_rd(5'd31, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0);
        check_rd("post_reset");

        // Write then read, plus same-cycle read during the write.
        wena  = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        set_rd(5'd5, 5'd1, 5'd0, Byp ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0);
        check_rd("same_cycle_rd");
        tick();
        wena = 1'b0;
        set_rd(5'd5, 5'd5, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        check_rd("rd_after_wr");
        check("wr_ok_no_drop", (NR*DW)'(wr_drop), '0);

        // Zero register: write discarded, never forwarded, not a refusal.
        wena  = 1'b1;
        waddr = 5'd0;
        wdata = 32'h1234;
        set_rd(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        check_rd("zero_fwd");
        tick();
        wena = 1'b0;
        set_rd(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        check_rd("zero_after");
        check("zero_no_drop", (NR*DW)'(wr_drop), '0);

        // Refused write at sweep cycle 10.
        write(5'd7, 32'h99);
        set_rd(5'd7, 5'd5, 5'd0, 32'h99, 32'hDEADBEEF, 32'h0);
        check_rd("r7_pre");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", (NR*DW)'(busy), (NR*DW)'(1));
        check("clr_no_drop", (NR*DW)'(wr_drop), '0);
        for (int i = 0; i < 10; i++) tick();
        write(5'd7, 32'h55);
        check("refused_drop", (NR*DW)'(wr_drop), (NR*DW)'(1));
        tick();
        check("refused_drop_one", (NR*DW)'(wr_drop), '0);
        wait_idle("refused_sweep", n);
        check("refused_sweep_rest", (NR*DW)'(n), (NR*DW)'(20));
        set_rd(5'd7, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0);
        check_rd("r7_post");

        // Clear mid-operation with a simultaneous write, then a restarted sweep.
        write(5'd3, 32'h7);
        write(5'd31, 32'h9);
        set_rd(5'd3, 5'd31, 5'd4, 32'h7, 32'h9, 32'h0);
        check_rd("pre_clr");
        clr   = 1'b1;
        wena  = 1'b1;
        waddr = 5'd4;
        wdata = 32'h1;
        set_rd(5'd4, 5'd3, 5'd0, 32'h0, 32'h7, 32'h0);
        check_rd("clr_no_fwd");
        tick();
        clr  = 1'b0;
        wena = 1'b0;
        check("clr_wr_drop", (NR*DW)'(wr_drop), (NR*DW)'(1));
        check("clr_busy2", (NR*DW)'(busy), (NR*DW)'(1));
        for (int i = 0; i < 10; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_idle("restart_sweep", n);
        check("restart_sweep_len", (NR*DW)'(n), (NR*DW)'(32));
        set_rd(5'd3, 5'd4, 5'd31, 32'h0, 32'h0, 32'h0);
        check_rd("post_clr");

        // Port independence.
        write(5'd1, 32'hA);
        write(5'd2, 32'hB);
        write(5'd3, 32'hC);
        set_rd(5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
        check_rd("ports_123");
        set_rd(5'd2, 5'd2, 5'd2, 32'hB, 32'hB, 32'hB);
        check_rd("ports_222");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
